bus_slave_mem: RTL and testbench

- Memory-backed responder for the req/ack/addr/cmd/wdata/rdata bus.
- Sits on a slave port of the 2x2 master/slave interconnect: it accepts one request at a time and returns ack plus rdata after a fixed programmable latency.
- Used as the downstream endpoint in system simulation and as a small on-chip scratch RAM.

---
 rtl/bus_slave_mem.sv | 177 +++++++++++++++++
 tb/tb_bus_slave_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_mem.sv
// bus_slave_mem
//   Memory-backed responder for the req/ack bus. Accepts one request at a
//   time and completes it with a single-cycle ack after LATENCY cycles.
//   Read data is presented with the ack. Writes commit on the edge that
//   enters the ack cycle.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high (memory is not cleared)
//   slave_req    request, held by the master until ack
//   slave_addr   byte address; word index = addr[AW+1:2]
//   slave_cmd    1 = write, 0 = read
//   slave_wdata  write data
//   slave_ack    one-cycle completion pulse
//   slave_rdata  read data, valid only while slave_ack = 1, else 0
//   busy         high from acceptance through the ack cycle
module bus_slave_mem #(
  parameter int N       = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         slave_req,
  input  logic [N-1:0] slave_addr,
  input  logic         slave_cmd,
  input  logic [N-1:0] slave_wdata,
  output logic         slave_ack,
  output logic [N-1:0] slave_rdata,
  output logic         busy
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1     = 4'(LATENCY - 1);
  localparam bit         LAT_IS_ONE = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [3:0]     cnt_r;
  logic [3:0]     cnt_nxt_s;
  logic           capture_s;
  logic           access_s;

  // Captured request (index and range flag are pre-decoded at capture)
  logic [AW-1:0]  idx_r;
  logic           inr_r;
  logic           cmd_r;
  logic [N-1:0]   wdata_r;

  // Operands of the access actually performed this edge
  logic [AW-1:0]  acc_idx_s;
  logic           acc_inr_s;
  logic           acc_cmd_s;
  logic [N-1:0]   acc_wdata_s;

  logic           ack_r;
  logic [N-1:0]   rdata_r;
  logic           busy_r;

  logic [N-1:0]   mem_r [DEPTH];

  // Byte-offset bits are intentionally ignored: access is word-granular.
  logic           unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^slave_addr[1:0];

  // An address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [N-1:0] a);
    return ((a >> (AW + 2)) == {N{1'b0}});
  endfunction

  // Next-state and counter logic for the IDLE/WAIT/ACK sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (slave_req) begin
          capture_s = 1'b1;
          cnt_nxt_s = LAT_M1;
          if (LAT_IS_ONE) begin
            // No wait phase: the access happens on the accepting edge.
            state_nxt_s = ST_ACK;
            access_s    = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_ACK;
          access_s    = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Select access operands: live bus in IDLE (LATENCY = 1 case), captured otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_idx_s   = slave_addr[AW+1:2];
      acc_inr_s   = addr_in_range(slave_addr);
      acc_cmd_s   = slave_cmd;
      acc_wdata_s = slave_wdata;
    end else begin
      acc_idx_s   = idx_r;
      acc_inr_s   = inr_r;
      acc_cmd_s   = cmd_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Sequencer state, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= {AW{1'b0}};
      inr_r   <= 1'b0;
      cmd_r   <= 1'b0;
      wdata_r <= {N{1'b0}};
      ack_r   <= 1'b0;
      rdata_r <= {N{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (capture_s) begin
        idx_r   <= slave_addr[AW+1:2];
        inr_r   <= addr_in_range(slave_addr);
        cmd_r   <= slave_cmd;
        wdata_r <= slave_wdata;
      end
      ack_r  <= access_s;
      busy_r <= (state_nxt_s != ST_IDLE);
      // Reads of out-of-range addresses and all writes return zero.
      if (access_s && !acc_cmd_s && acc_inr_s) begin
        rdata_r <= mem_r[acc_idx_s];
      end else begin
        rdata_r <= {N{1'b0}};
      end
    end
  end

  // Storage write port; a reset on the access edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && access_s && acc_cmd_s && acc_inr_s) begin
      mem_r[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign slave_ack   = ack_r;
  assign slave_rdata = rdata_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_bus_slave_mem.sv
module tb_bus_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_run = 0;
  int          n_fail = 0;

  // Main DUT, LATENCY = 2
  logic        req = 1'b0, cmd = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ack, busy;
  logic [31:0] rdata;

  // LATENCY = 1 and LATENCY = 15 builds
  logic        req1 = 1'b0, cmd1 = 1'b0, req15 = 1'b0, cmd15 = 1'b0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0, addr15 = 32'h0, wdata15 = 32'h0;
  logic        ack1, busy1, ack15, busy15;
  logic [31:0] rdata1, rdata15;

  bus_slave_mem #(.N(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .slave_req(req), .slave_addr(addr), .slave_cmd(cmd),
    .slave_wdata(wdata), .slave_ack(ack), .slave_rdata(rdata), .busy(busy));

  bus_slave_mem #(.N(32), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .slave_req(req1), .slave_addr(addr1), .slave_cmd(cmd1),
    .slave_wdata(wdata1), .slave_ack(ack1), .slave_rdata(rdata1), .busy(busy1));

  bus_slave_mem #(.N(32), .DEPTH(256), .LATENCY(15)) dut15 (
    .clk(clk), .rst(rst), .slave_req(req15), .slave_addr(addr15), .slave_cmd(cmd15),
    .slave_wdata(wdata15), .slave_ack(ack15), .slave_rdata(rdata15), .busy(busy15));

  always #5 clk = ~clk;

  // Cycle number: value after each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cycle;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every ack of the main DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cycle));
        check("ack_rdata", rdata, e.rdata);
      end
    end
  end

  // One transaction on the main DUT: drive, wait for ack, drop req.
  task automatic do_txn(input logic [31:0] a, input logic c, input logic [31:0] w,
                        input logic [31:0] exp);
    bit seen;
    exp_t e;
    seen = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; addr = a; cmd = c; wdata = w;
    e.cycle = cyc + 2; e.rdata = exp;
    sb_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        seen = 1'b1;
        check("busy_in_ack", 32'(busy), 32'd1);
        break;
      end
    end
    if (!seen) check("txn_timeout", 32'd0, 32'd1);
    req = 1'b0;
  endtask

  // One transaction on the LATENCY=1 (sel=1) or LATENCY=15 build.
  task automatic run_l(input int sel, input logic [31:0] a, input logic c,
                       input logic [31:0] w, output int lat, output int bc,
                       output logic [31:0] rd);
    int start;
    logic a_s, b_s;
    lat = -1; bc = 0; rd = 32'h0;
    @(posedge clk); #1;
    start = cyc;
    if (sel == 1) begin
      req1 = 1'b1; addr1 = a; cmd1 = c; wdata1 = w;
    end else begin
      req15 = 1'b1; addr15 = a; cmd15 = c; wdata15 = w;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a_s = (sel == 1) ? ack1 : ack15;
      b_s = (sel == 1) ? busy1 : busy15;
      if (b_s === 1'b1) bc++;
      if (a_s === 1'b1) begin
        lat = cyc - start;
        rd = (sel == 1) ? rdata1 : rdata15;
        break;
      end
    end
    req1 = 1'b0; req15 = 1'b0;
  endtask

  initial begin
    int          lat, bc;
    logic [31:0] rd;
    int          c0;
    exp_t        e;

    vecs[0]  = '{32'h0000_0010, 1'b1, 32'hA5A5_1234, 32'h0};
    vecs[1]  = '{32'h0000_0010, 1'b0, 32'h0,         32'hA5A5_1234};
    vecs[2]  = '{32'h0000_0000, 1'b1, 32'h1,         32'h0};
    vecs[3]  = '{32'h0000_0004, 1'b1, 32'h2,         32'h0};
    vecs[4]  = '{32'h0000_0008, 1'b1, 32'h3,         32'h0};
    vecs[5]  = '{32'h0000_0400, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{32'h0000_0000, 1'b0, 32'h0,         32'h1};
    vecs[7]  = '{32'h0000_0400, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{32'h0000_0013, 1'b0, 32'h0,         32'hA5A5_1234};
    vecs[9]  = '{32'h0000_0020, 1'b1, 32'h77,        32'h0};
    vecs[10] = '{32'h0000_0020, 1'b0, 32'h0,         32'h77};
    vecs[11] = '{32'h8000_0008, 1'b0, 32'h0,         32'h0};

    // Reset held with req high: outputs stay quiet.
    rst = 1'b1; req = 1'b1; cmd = 1'b0; addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    // First acceptance in the cycle after rst drops.
    @(posedge clk); #1;
    rst = 1'b0; cmd = 1'b1; addr = 32'h40; wdata = 32'hDEAD;
    e.cycle = cyc + 2; e.rdata = 32'h0;
    sb_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack === 1'b1) break;
    end
    req = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].addr, vecs[i].cmd, vecs[i].wdata, vecs[i].exp);
    end

    // Back-to-back: req held across three reads, acks 3 cycles apart.
    @(posedge clk); #1;
    req = 1'b1; cmd = 1'b0; addr = 32'h0;
    c0 = cyc;
    e.cycle = c0 + 2; e.rdata = 32'h1; sb_q.push_back(e);
    e.cycle = c0 + 5; e.rdata = 32'h2; sb_q.push_back(e);
    e.cycle = c0 + 8; e.rdata = 32'h3; sb_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ack === 1'b1) begin seen = 1'b1; break; end
      end
      if (!seen) check("b2b_timeout", 32'd0, 32'd1);
      if (k == 0) addr = 32'h4;
      else if (k == 1) addr = 32'h8;
      else req = 1'b0;
    end

    // Reset during WAIT: write aborted, no ack.
    @(posedge clk); #1;
    req = 1'b1; cmd = 1'b1; addr = 32'h20; wdata = 32'h55;
    @(posedge clk); #1;
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    do_txn(32'h20, 1'b0, 32'h0, 32'h77);

    // LATENCY = 1 build.
    run_l(1, 32'h8, 1'b1, 32'h1111, lat, bc, rd);
    check("l1_wr_lat", 32'(lat), 32'd1);
    run_l(1, 32'h8, 1'b0, 32'h0, lat, bc, rd);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd_data", rd, 32'h1111);
    check("l1_busy_cycles", 32'(bc), 32'd1);

    // LATENCY = 15 build.
    run_l(15, 32'hC, 1'b1, 32'h2222, lat, bc, rd);
    check("l15_wr_lat", 32'(lat), 32'd15);
    check("l15_busy_cycles", 32'(bc), 32'd15);
    run_l(15, 32'hC, 1'b0, 32'h0, lat, bc, rd);
    check("l15_rd_lat", 32'(lat), 32'd15);
    check("l15_rd_data", rd, 32'h2222);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
